// File: rtl/elevator_ctrl_n.sv
`default_nettype none
// ============================================================================
// Module   : elevator_ctrl_n
// Purpose  : N-floor elevator car controller. Latches floor calls into a
//            pending register and serves them in SCAN order. Counters time
//            the travel between floors and the door dwell.
// Ports    : clk       - system clock (rising edge)
//            reset     - asynchronous, active-high reset
//            call      - per-floor call request, sampled every cycle
//            hold      - door hold, extends dwell while the door is open
//            floor     - current car floor
//            door_open - high while the door is open
//            moving    - high while the car travels between floors
//            dir_up    - travel direction (1 = up, 0 = down)
//            pending   - latched requests not yet served
// Revision : 1.0 - initial release
// ============================================================================
module elevator_ctrl_n #(
  parameter int N_FLOORS    = 4,
  parameter int FLOOR_W     = 2,
  parameter int MOVE_CYCLES = 2,
  parameter int DOOR_CYCLES = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [N_FLOORS-1:0] call,
  input  logic                hold,
  output logic [FLOOR_W-1:0]  floor,
  output logic                door_open,
  output logic                moving,
  output logic                dir_up,
  output logic [N_FLOORS-1:0] pending
);

  localparam int C_TMAX  = (MOVE_CYCLES > DOOR_CYCLES) ? MOVE_CYCLES : DOOR_CYCLES;
  localparam int C_TMR_W = (C_TMAX > 1) ? $clog2(C_TMAX) : 1;
  localparam int C_PAD   = 2 ** FLOOR_W;
  localparam logic [C_TMR_W-1:0] C_MOVE_LD = C_TMR_W'(MOVE_CYCLES - 1);
  localparam logic [C_TMR_W-1:0] C_DOOR_LD = C_TMR_W'(DOOR_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MOVE = 2'd1,
    S_DOOR = 2'd2
  } state_t;

  state_t              r_state;
  logic [C_TMR_W-1:0]  r_timer;
  logic [FLOOR_W-1:0]  r_floor;
  logic                r_door_open;
  logic                r_moving;
  logic                r_dir_up;
  logic [N_FLOORS-1:0] r_pending;

  logic [FLOOR_W-1:0]  w_floor_nx;   // floor the car reaches at the end of this hop
  logic [C_PAD-1:0]    w_pend_pad;   // pending widened to the full floor index range
  logic [C_PAD-1:0]    w_call_pad;
  logic [C_PAD-1:0]    w_clr_pad;
  logic                w_above;
  logic                w_below;
  logic                w_ahead_nx;   // requests beyond the next floor in the travel direction
  logic                w_here;
  logic                w_arrive_stop;
  logic                w_call_here;

  always_comb begin
    w_pend_pad                 = '0;
    w_pend_pad[N_FLOORS-1:0]   = r_pending;
    w_call_pad                 = '0;
    w_call_pad[N_FLOORS-1:0]   = call;
    w_floor_nx = r_dir_up ? (r_floor + FLOOR_W'(1)) : (r_floor - FLOOR_W'(1));
    w_above    = 1'b0;
    w_below    = 1'b0;
    w_ahead_nx = 1'b0;
    for (int i = 0; i < N_FLOORS; i++) begin
      if (r_pending[i]) begin
        if (i > int'(r_floor)) w_above = 1'b1;
        if (i < int'(r_floor)) w_below = 1'b1;
        if (r_dir_up ? (i > int'(w_floor_nx)) : (i < int'(w_floor_nx))) w_ahead_nx = 1'b1;
      end
    end
    w_here        = w_pend_pad[r_floor];
    w_arrive_stop = w_pend_pad[w_floor_nx];
    w_call_here   = w_call_pad[r_floor];

    // The request being served is cleared while the door is open and at the
    // very edge the door opens, so a call for that floor is never retained.
    w_clr_pad = '0;
    if (r_state == S_DOOR || (r_state == S_IDLE && w_here)) begin
      w_clr_pad[r_floor] = 1'b1;
    end else if (r_state == S_MOVE && r_timer == '0 && w_arrive_stop) begin
      w_clr_pad[w_floor_nx] = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_timer     <= '0;
      r_floor     <= '0;
      r_door_open <= 1'b0;
      r_moving    <= 1'b0;
      r_dir_up    <= 1'b1;
      r_pending   <= '0;
    end else begin
      r_pending <= (r_pending | call) & ~w_clr_pad[N_FLOORS-1:0];
      case (r_state)
        S_IDLE: begin
          if (w_here) begin
            r_state     <= S_DOOR;
            r_timer     <= C_DOOR_LD;
            r_door_open <= 1'b1;
          end else if ((r_dir_up && w_above) || (!r_dir_up && w_below)) begin
            // keep the current direction while work remains ahead
            r_state  <= S_MOVE;
            r_timer  <= C_MOVE_LD;
            r_moving <= 1'b1;
          end else if (w_above || w_below) begin
            // nothing ahead: reverse towards the remaining requests
            r_state  <= S_MOVE;
            r_timer  <= C_MOVE_LD;
            r_moving <= 1'b1;
            r_dir_up <= w_above;
          end
        end
        S_MOVE: begin
          if (r_timer != '0) begin
            r_timer <= r_timer - C_TMR_W'(1);
          end else begin
            r_floor <= w_floor_nx;
            if (w_arrive_stop) begin
              r_state     <= S_DOOR;
              r_timer     <= C_DOOR_LD;
              r_door_open <= 1'b1;
              r_moving    <= 1'b0;
            end else if (w_ahead_nx) begin
              r_timer <= C_MOVE_LD;
            end else begin
              r_state  <= S_IDLE;
              r_moving <= 1'b0;
            end
          end
        end
        S_DOOR: begin
          if (hold || w_call_here) begin
            r_timer <= C_DOOR_LD;
          end else if (r_timer != '0) begin
            r_timer <= r_timer - C_TMR_W'(1);
          end else begin
            r_state     <= S_IDLE;
            r_door_open <= 1'b0;
          end
        end
        default: begin
          r_state     <= S_IDLE;
          r_door_open <= 1'b0;
          r_moving    <= 1'b0;
        end
      endcase
    end
  end

  assign floor     = r_floor;
  assign door_open = r_door_open;
  assign moving    = r_moving;
  assign dir_up    = r_dir_up;
  assign pending   = r_pending;

endmodule
`default_nettype wire

// File: tb/tb_elevator_ctrl_n.sv
`default_nettype none
// ============================================================================
// Module   : tb_elevator_ctrl_n
// Purpose  : Self-checking bench for elevator_ctrl_n (N=4, MOVE=2, DOOR=4).
//            Table vectors, directed multi-cycle sequences and random
//            traffic compared against a behavioural car model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_elevator_ctrl_n;

  localparam int N  = 4;
  localparam int FW = 2;
  localparam int MC = 2;
  localparam int DC = 4;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [N-1:0]  call = '0;
  logic          hold = 1'b0;
  logic [FW-1:0] floor;
  logic          door_open;
  logic          moving;
  logic          dir_up;
  logic [N-1:0]  pending;

  elevator_ctrl_n #(
    .N_FLOORS(N), .FLOOR_W(FW), .MOVE_CYCLES(MC), .DOOR_CYCLES(DC)
  ) dut (
    .clk(clk), .reset(reset), .call(call), .hold(hold),
    .floor(floor), .door_open(door_open), .moving(moving),
    .dir_up(dir_up), .pending(pending)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // mode: 0 waiting, 1 travelling, 2 door open; rem = cycles left in phase
  int       m_mode, m_floor, m_rem;
  bit       m_up;
  bit [N-1:0] m_pend;

  function automatic void model_reset();
    m_mode = 0; m_floor = 0; m_rem = 0; m_up = 1'b1; m_pend = '0;
  endfunction

  function automatic bit req_in(int lo, int hi);
    for (int i = lo; i <= hi; i++)
      if (i >= 0 && i < N && m_pend[i]) return 1'b1;
    return 1'b0;
  endfunction

  function automatic void model_step(input logic [N-1:0] c, input logic h);
    int clr = -1;
    bit above = req_in(m_floor + 1, N - 1);
    bit below = req_in(0, m_floor - 1);
    case (m_mode)
      0: begin
        if (m_pend[m_floor]) begin
          m_mode = 2; m_rem = DC; clr = m_floor;
        end else if ((m_up && above) || (!m_up && below)) begin
          m_mode = 1; m_rem = MC;
        end else if (above) begin
          m_mode = 1; m_rem = MC; m_up = 1'b1;
        end else if (below) begin
          m_mode = 1; m_rem = MC; m_up = 1'b0;
        end
      end
      1: begin
        m_rem--;
        if (m_rem == 0) begin
          m_floor += m_up ? 1 : -1;
          if (m_pend[m_floor]) begin
            m_mode = 2; m_rem = DC; clr = m_floor;
          end else if (m_up ? req_in(m_floor + 1, N - 1) : req_in(0, m_floor - 1)) begin
            m_rem = MC;
          end else begin
            m_mode = 0;
          end
        end
      end
      default: begin
        clr = m_floor;
        if (h || c[m_floor]) m_rem = DC;
        else begin
          m_rem--;
          if (m_rem == 0) m_mode = 0;
        end
      end
    endcase
    for (int i = 0; i < N; i++)
      m_pend[i] = (m_pend[i] | c[i]) && (i != clr);
  endfunction

  task automatic check_model();
    chk("mdl_floor",   32'(floor),     32'(m_floor));
    chk("mdl_door",    32'(door_open), 32'(m_mode == 2));
    chk("mdl_moving",  32'(moving),    32'(m_mode == 1));
    chk("mdl_dir",     32'(dir_up),    32'(m_up));
    chk("mdl_pending", 32'(pending),   32'(m_pend));
  endtask

  task automatic tick(input logic [N-1:0] c, input logic h);
    @(negedge clk);
    call = c; hold = h;
    @(posedge clk);
    model_step(c, h);
    #1;
    check_model();
  endtask

  // Reset pulse placed between clock edges; optionally checks the outputs
  // while reset is still asserted to prove it acts without a clock edge.
  task automatic do_reset(input bit chk_now);
    @(negedge clk);
    #1;
    reset = 1'b1; call = '0; hold = 1'b0;
    #1;
    model_reset();
    if (chk_now) begin
      chk("rst_floor",   32'(floor),     0);
      chk("rst_door",    32'(door_open), 0);
      chk("rst_moving",  32'(moving),    0);
      chk("rst_dir",     32'(dir_up),    1);
      chk("rst_pending", 32'(pending),   0);
    end
    #1;
    reset = 1'b0;
    @(posedge clk);
    model_step('0, 1'b0);
    #1;
    check_model();
  endtask

  typedef struct {
    logic [N-1:0]  c;
    logic          h;
    logic [FW-1:0] fl;
    logic          dr;
    logic          mv;
    logic          up;
    logic [N-1:0]  pd;
  } vec_t;

  vec_t tbl[11];

  initial begin
    int stops[$];
    int lens[$];
    int pends[$];
    int cnt;
    bit prev;
    bit seen;
    logic [N-1:0] rc;

    tbl[0]  = '{4'b0100, 1'b0, 2'd0, 1'b0, 1'b0, 1'b1, 4'b0100};
    tbl[1]  = '{4'b0000, 1'b0, 2'd0, 1'b0, 1'b1, 1'b1, 4'b0100};
    tbl[2]  = '{4'b0000, 1'b0, 2'd0, 1'b0, 1'b1, 1'b1, 4'b0100};
    tbl[3]  = '{4'b0000, 1'b0, 2'd1, 1'b0, 1'b1, 1'b1, 4'b0100};
    tbl[4]  = '{4'b0000, 1'b0, 2'd1, 1'b0, 1'b1, 1'b1, 4'b0100};
    tbl[5]  = '{4'b0000, 1'b0, 2'd2, 1'b1, 1'b0, 1'b1, 4'b0000};
    tbl[6]  = '{4'b0000, 1'b0, 2'd2, 1'b1, 1'b0, 1'b1, 4'b0000};
    tbl[7]  = '{4'b0000, 1'b0, 2'd2, 1'b1, 1'b0, 1'b1, 4'b0000};
    tbl[8]  = '{4'b0000, 1'b0, 2'd2, 1'b1, 1'b0, 1'b1, 4'b0000};
    tbl[9]  = '{4'b0000, 1'b0, 2'd2, 1'b0, 1'b0, 1'b1, 4'b0000};
    tbl[10] = '{4'b0000, 1'b0, 2'd2, 1'b0, 1'b0, 1'b1, 4'b0000};

    model_reset();
    #12;

    // Reset state, then a single call to floor 2 traced cycle by cycle
    do_reset(1'b1);
    for (int i = 0; i < 11; i++) begin
      tick(tbl[i].c, tbl[i].h);
      chk($sformatf("vec%0d_floor", i),   32'(floor),     32'(tbl[i].fl));
      chk($sformatf("vec%0d_door", i),    32'(door_open), 32'(tbl[i].dr));
      chk($sformatf("vec%0d_moving", i),  32'(moving),    32'(tbl[i].mv));
      chk($sformatf("vec%0d_dir", i),     32'(dir_up),    32'(tbl[i].up));
      chk($sformatf("vec%0d_pending", i), 32'(pending),   32'(tbl[i].pd));
    end

    // SCAN: moving up past floor 1 with floors 3 and 0 pending
    do_reset(1'b0);
    tick(4'b1000, 1'b0);
    tick(4'b0001, 1'b0);
    for (int i = 0; i < 10 && !(floor == 2'd1 && moving); i++) tick('0, 1'b0);
    chk("scan_setup_floor", 32'(floor), 1);
    chk("scan_setup_pend",  32'(pending), 32'(4'b1001));
    chk("scan_setup_dir",   32'(dir_up), 1);
    stops.delete();
    prev = door_open;
    for (int i = 0; i < 60; i++) begin
      tick('0, 1'b0);
      if (door_open && !prev) stops.push_back(int'(floor));
      prev = door_open;
      if (door_open && floor == 2'd0) break;
    end
    chk("scan_nstops", 32'(stops.size()), 2);
    chk("scan_stop0", (stops.size() > 0) ? 32'(stops[0]) : 32'hFFFF, 3);
    chk("scan_stop1", (stops.size() > 1) ? 32'(stops[1]) : 32'hFFFF, 0);
    chk("scan_dir_down", 32'(dir_up), 0);

    // Door hold for 6 cycles, then a re-call for the current floor
    do_reset(1'b0);
    tick(4'b0100, 1'b0);
    for (int i = 0; i < 20 && !door_open; i++) tick('0, 1'b0);
    chk("hold_door_up", 32'(door_open), 1);
    chk("hold_floor",   32'(floor), 2);
    cnt = 1;
    for (int i = 0; i < 6; i++) begin
      tick('0, 1'b1);
      if (door_open) cnt++;
    end
    for (int i = 0; i < 20; i++) begin
      tick('0, 1'b0);
      if (door_open) cnt++; else break;
    end
    chk("hold_door_len", 32'(cnt), 6 + DC);
    tick(4'b0100, 1'b0);
    chk("recall_latch", 32'(pending), 32'(4'b0100));
    tick('0, 1'b0);
    chk("recall_door", 32'(door_open), 1);
    cnt = 1;
    tick(4'b0100, 1'b0);
    chk("recall_not_latched", 32'(pending), 0);
    if (door_open) cnt++;
    for (int i = 0; i < 20; i++) begin
      tick('0, 1'b0);
      if (door_open) cnt++; else break;
    end
    chk("recall_door_len", 32'(cnt), 1 + DC);

    // Call at the car's own floor while idle
    do_reset(1'b0);
    tick(4'b0001, 1'b0);
    chk("own_pend", 32'(pending), 1);
    chk("own_door_wait", 32'(door_open), 0);
    tick('0, 1'b0);
    chk("own_door", 32'(door_open), 1);
    chk("own_floor", 32'(floor), 0);
    seen = moving;
    cnt = 1;
    for (int i = 0; i < 6; i++) begin
      tick('0, 1'b0);
      if (moving) seen = 1'b1;
      if (door_open) cnt++;
    end
    chk("own_never_moves", 32'(seen), 0);
    chk("own_door_len", 32'(cnt), DC);

    // All floors called at once from floor 0
    do_reset(1'b0);
    tick(4'b1111, 1'b0);
    stops.delete(); lens.delete(); pends.delete();
    prev = 1'b0;
    cnt = 0;
    for (int i = 0; i < 80 && lens.size() < 4; i++) begin
      tick('0, 1'b0);
      if (door_open && !prev) begin
        stops.push_back(int'(floor));
        pends.push_back(int'(pending));
        cnt = 1;
      end else if (door_open) begin
        cnt++;
      end else if (prev) begin
        lens.push_back(cnt);
      end
      prev = door_open;
    end
    chk("all_nstops", 32'(lens.size()), 4);
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("all_stop%0d_floor", k), (stops.size() > k) ? 32'(stops[k]) : 32'hFFFF, 32'(k));
      chk($sformatf("all_stop%0d_len", k),   (lens.size()  > k) ? 32'(lens[k])  : 32'hFFFF, DC);
      chk($sformatf("all_stop%0d_pend", k),  (pends.size() > k) ? 32'(pends[k]) : 32'hFFFF,
          32'((4'b1111 << (k + 1)) & 4'b1111));
    end

    // Asynchronous reset in the middle of a hop from floor 1 to 2
    do_reset(1'b0);
    tick(4'b0100, 1'b0);
    for (int i = 0; i < 10 && !(floor == 2'd1 && moving); i++) tick('0, 1'b0);
    chk("arst_setup_floor", 32'(floor), 1);
    chk("arst_setup_moving", 32'(moving), 1);
    do_reset(1'b1);
    tick(4'b0010, 1'b0);
    for (int i = 0; i < 20 && !door_open; i++) tick('0, 1'b0);
    chk("arst_resume_door", 32'(door_open), 1);
    chk("arst_resume_floor", 32'(floor), 1);

    // Random traffic against the model
    for (int n = 0; n < 2000; n++) begin
      if ($urandom_range(0, 249) == 0) begin
        do_reset(1'b1);
      end else begin
        rc = '0;
        for (int b = 0; b < N; b++) rc[b] = ($urandom_range(0, 11) == 0);
        tick(rc, $urandom_range(0, 9) == 0);
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/elevator_ctrl_n.md
Name: elevator_ctrl_n

Overview:
Parametrised N-floor car controller. It is the successor to the 3-floor, one-call-at-a-time floor FSM.
- Latches call requests from every floor into a pending register.
- Serves requests in SCAN order: keeps the current direction while requests remain ahead of the car.
- Times car travel between floors and door dwell with counters; a hold input extends the dwell.
- Sits between the debounced call-button inputs and the floor/door indicator logic.

Parameters:
N_FLOORS, 4, number of floors (2..16); floors numbered 0..N_FLOORS-1.
FLOOR_W, 2, width of the floor index; must satisfy 2^FLOOR_W >= N_FLOORS.
MOVE_CYCLES, 2, clock cycles to travel one floor (>=1).
DOOR_CYCLES, 4, clock cycles the door stays open with no hold or re-call (>=1).

Ports:
clk  in  1  system clock; all state changes on its rising edge.
reset  in  1  asynchronous, active-high reset.
call  in  N_FLOORS  call request per floor; level-sampled every cycle.
hold  in  1  door hold (obstruction / open button); effective only while the door is open.
floor  out  FLOOR_W  current car floor.
door_open  out  1  door open; high exactly while the FSM is in DOOR.
moving  out  1  high while the FSM is in MOVE.
dir_up  out  1  current travel direction: 1 = up, 0 = down.
pending  out  N_FLOORS  latched, not-yet-served requests.

Behaviour:
Reset (asynchronous, active-high):
- state=IDLE, floor=0, door_open=0, moving=0, dir_up=1, pending=0, timer=0.
- Reset asserted mid-MOVE or mid-DOOR returns the car to floor 0 immediately. No request is retained.

Request latching, each edge:
- pending <= (pending | call) & ~clr.
- clr = one-hot(floor) when the FSM is in DOOR, or is entering DOOR at this edge; otherwise 0.
- A call for the current floor while in DOOR is never latched. Instead it reloads the door timer.

Direction terms (combinational, from registered pending and floor):
- ABOVE = any pending bit above floor.
- BELOW = any pending bit below floor.

IDLE:
- pending[floor] → DOOR; load timer=DOOR_CYCLES-1.
- else dir_up & ABOVE → MOVE, dir_up=1.
- else ~dir_up & BELOW → MOVE, dir_up=0.
- else ABOVE → MOVE, dir_up=1 (reverse).
- else BELOW → MOVE, dir_up=0 (reverse).
- else stay IDLE.
- On entering MOVE, load timer=MOVE_CYCLES-1.

MOVE:
- timer≠0: decrement timer.
- timer==0 at an edge: floor <= floor±1 according to dir_up. The next state is then decided on the new floor:
  - pending[new floor] → DOOR.
  - else requests remain ahead in dir_up → MOVE (reload timer).
  - else → IDLE.
- One floor therefore takes exactly MOVE_CYCLES cycles.
- floor is never driven outside 0..N_FLOORS-1. MOVE is only entered, or continued, when a request exists in that direction.

DOOR:
- door_open=1.
- hold=1, or call[floor]=1, reloads timer=DOOR_CYCLES-1.
- else timer≠0: decrement timer.
- else (timer==0): → IDLE.
- Without hold or re-call, door_open is high for exactly DOOR_CYCLES cycles.
- Calls for other floors keep latching while in DOOR.

Latency:
- A call asserted in the cycle before edge k sets pending at edge k.
- IDLE acts on that request at edge k+1.

Simultaneous events:
- A call for a floor being passed mid-MOVE is latched. It stops the car only if the bit is already pending when the car arrives at that floor.
- Inputs that go X are not tolerated; the bench must drive all inputs to known values.

Test Plan:
1. Reset, then call[2] pulse for 1 cycle (N=4, MOVE=2, DOOR=4) → pending=0100 at the next edge; IDLE→MOVE; floor reaches 1 and then 2, two cycles each; door_open high for 4 cycles with pending=0000; then IDLE at floor 2.
2. Car at floor 1 moving up, pending floors 3 and 0 → serves 3 first, then reverses (dir_up=0), travels 3→0 without stopping at 2 or 1, and opens the door at 0.
3. Door open at floor 2, hold held for 6 cycles → door_open stays high for those 6 cycles plus 4 after release. A call[2] pulse during DOOR also reloads the timer and pending[2] stays 0.
4. Idle at floor 0 with call[0] asserted → DOOR on the following edge; floor stays 0 and moving never rises.
5. All calls asserted together from floor 0 → stops at 0, 1, 2, 3 in order, each stop lasting DOOR_CYCLES; pending clears bit by bit.
6. Reset asserted mid-MOVE between floors 1 and 2 → floor=0, moving=0, pending=0 immediately, without waiting for a clock edge; the FSM resumes normally after reset is released.
